// File: rtl/fft_pkg.sv
// Shared types and configuration checks for the FFT scaling controller.
package fft_pkg;

   typedef enum logic [1:0] {
      NONE  = 2'b00,
      FIXED = 2'b01,
      BFP   = 2'b10,
      RSVD  = 2'b11
   } scale_mode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      UPDATE = 2'd2,
      DONE   = 2'd3
   } ctrl_state_t;

   localparam int LEGAL_WIDTH_NARROW = 8;
   localparam int LEGAL_SHAMT_NARROW = 4;
   localparam int LEGAL_WIDTH_WIDE   = 16;
   localparam int LEGAL_SHAMT_WIDE   = 5;

   function automatic bit legal_shift_cfg(input int width, input int shamtbits);
      return ((width == LEGAL_WIDTH_NARROW) && (shamtbits == LEGAL_SHAMT_NARROW)) ||
             ((width == LEGAL_WIDTH_WIDE)   && (shamtbits == LEGAL_SHAMT_WIDE));
   endfunction

   // Next stage shifts by one when scaling is forced, or when BFP saw growth.
   function automatic logic next_shift_one(input scale_mode_t mode, input logic grow);
      case (mode)
         NONE:    return 1'b0;
         BFP:     return grow;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/clk_rstn_intrf.sv
// Clock and asynchronous active-low reset bundle.
interface clk_rstn_intrf;
   logic clk;
   logic rstn;

   modport master (output clk, output rstn);
   modport slave  (input clk, input rstn);
endinterface

// File: rtl/growth_detect.sv
// Flags any of four width+1-bit signed lanes that does not fit in width signed bits.
module growth_detect #(
   parameter int width = 8
) (
   input  logic [0:3][width:0] data,
   output logic                any_grow
);

   localparam logic signed [width:0] max_val = {2'b00, {(width-1){1'b1}}};
   localparam logic signed [width:0] min_val = {2'b11, {(width-1){1'b0}}};

   // Range compare is equivalent to the top two bits disagreeing.
   always_comb begin
      any_grow = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (($signed(data[k]) > max_val) || ($signed(data[k]) < min_val)) begin
            any_grow = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fft_scale_ctrl.sv
// Stage sequencer and scaling scheduler: holds the shifter's amount per stage,
// picks the next stage's shift from observed bit growth and totals the block exponent.
module fft_scale_ctrl
   import fft_pkg::*;
#(
   parameter int width     = 8,
   parameter int shamtbits = 4,
   parameter int stagebits = 4,
   parameter int expbits   = 8
) (
   clk_rstn_intrf.slave               clk_rstn_i,
   input  logic                       start_i,
   input  logic [stagebits-1:0]       n_stages_i,
   input  logic [1:0]                 mode_i,
   input  logic [shamtbits-1:0]       init_shamt_i,
   input  logic                       mon_tvalid_i,
   input  logic                       mon_tready_i,
   input  logic                       mon_tlast_i,
   input  logic [0:3][width:0]        mon_data_i,
   output logic [shamtbits-1:0]       shamt_o,
   output logic [stagebits-1:0]       stage_o,
   output logic                       stage_go_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [expbits-1:0]         exp_o
);

   if (!legal_shift_cfg(width, shamtbits)) begin : g_illegal_cfg
      $error("fft_scale_ctrl: unsupported (width, shamtbits) = (%0d, %0d)", width, shamtbits);
   end

   localparam int sumbits = ((expbits > shamtbits) ? expbits : shamtbits) + 1;

   ctrl_state_t            state_q, state_d;
   scale_mode_t            mode_q;
   logic [stagebits-1:0]   n_stages_q, stage_q;
   logic [shamtbits-1:0]   shamt_q, shamt_next;
   logic [expbits-1:0]     exp_q, exp_sat;
   logic [sumbits-1:0]     exp_sum;
   logic                   grow_q, any_grow, beat, last_stage, stage_go_q;
   logic                   zero_run_q;

   growth_detect #(.width(width)) u_growth_detect (
      .data     (mon_data_i),
      .any_grow (any_grow)
   );

   assign beat       = mon_tvalid_i & mon_tready_i;
   assign last_stage = (stage_q == n_stages_q - stagebits'(1));
   assign shamt_next = shamtbits'(next_shift_one(mode_q, grow_q));
   assign exp_sum    = sumbits'(exp_q) + sumbits'(shamt_q);
   assign exp_sat    = (exp_sum > sumbits'({expbits{1'b1}})) ? {expbits{1'b1}}
                                                             : exp_sum[expbits-1:0];

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_rstn_i.clk or negedge clk_rstn_i.rstn) begin
      if (!clk_rstn_i.rstn) begin
         state_q    <= IDLE;
         mode_q     <= NONE;
         n_stages_q <= '0;
         stage_q    <= '0;
         shamt_q    <= '0;
         exp_q      <= '0;
         grow_q     <= 1'b0;
         stage_go_q <= 1'b0;
         zero_run_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         stage_go_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  mode_q     <= scale_mode_t'(mode_i);
                  n_stages_q <= n_stages_i;
                  stage_q    <= '0;
                  shamt_q    <= init_shamt_i;
                  exp_q      <= '0;
                  grow_q     <= 1'b0;
                  stage_go_q <= (n_stages_i != '0);
                  zero_run_q <= (n_stages_i == '0);
               end
            end
            RUN: begin
               if (beat && any_grow) begin
                  grow_q <= 1'b1;
               end
            end
            UPDATE: begin
               exp_q <= exp_sat;
               if (!last_stage) begin
                  stage_q    <= stage_q + stagebits'(1);
                  shamt_q    <= shamt_next;
                  grow_q     <= 1'b0;
                  stage_go_q <= 1'b1;
               end
            end
            DONE: begin
               zero_run_q <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: state_d gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (start_i) state_d = (n_stages_i == '0) ? DONE : RUN;
         RUN:    if (beat && mon_tlast_i) state_d = UPDATE;
         UPDATE: state_d = last_stage ? DONE : RUN;
         // An empty transform lingers one extra cycle so done keeps its two-cycle latency.
         DONE:   state_d = zero_run_q ? DONE : IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q == RUN) || (state_q == UPDATE);
      done_o = (state_q == DONE) && !zero_run_q;
   end

   assign shamt_o    = shamt_q;
   assign stage_o    = stage_q;
   assign stage_go_o = stage_go_q;
   assign exp_o      = exp_q;

endmodule
